fft_bin_levels: RTL
===================

# fft_bin_levels

Downstream consumer of the `fftmain` output stream. It converts the first `BINS` complex bins of each FFT frame into saturated 8-bit energy levels with per-bin peak-hold and linear decay. It presents all levels in parallel, frame-coherently, to the gamma LUT / PWM stage. It replaces ad-hoc bin capture with a double-buffered, sync-qualified pipeline.

## Interface
Parameters:
- `WIDTH`, 12: signed width of each FFT real/imag output.
- `BINS`, 8: number of bins captured per frame, starting at bin 0 (1..64).
- `SHIFT`, 6: right-shift applied to bin power before saturation.
- `DECAY`, 4: amount subtracted from a held level each committed frame.

Ports:
- `clk`, in, 1: system clock (32 MHz PLL clock).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ce`, in, 1: sample strobe. It is the same enable as the FFT's `i_ce`. Inputs are valid only when `ce`=1.
- `sync`, in, 1: FFT `o_sync`. When high with `ce`, the current `re`/`im` is bin 0 of a new frame.
- `re`, in, `WIDTH`: signed real part of the current bin.
- `im`, in, `WIDTH`: signed imaginary part of the current bin.
- `levels`, out, `BINS*8`: held levels. Bin i occupies `levels[8*i+7:8*i]`.
- `frame_valid`, out, 1: one-cycle pulse. Asserted on the cycle `levels` takes a new frame's values.

## Operation
- Capture FSM states:
  - `WAIT_SYNC` (reset state). Ignores all samples until `ce && sync`.
  - `CAPTURE`. Index counter `idx` runs 0..`BINS`-1.
  - `HOLD`. Ignores samples until the next `ce && sync`.
- `ce && sync` in any state captures the sample as bin 0, sets `idx`=1, and enters `CAPTURE`.
- `ce && !sync` in `CAPTURE` captures the sample as bin `idx` and increments `idx`. Capturing bin `BINS`-1 enters `HOLD`.
- `ce`=0: no state change, and `re`/`im` are ignored.
- Power, unsigned `2*WIDTH` bits: `p = re*re + im*im`. It cannot overflow, because the maximum is 2^(2*WIDTH-1).
- Scaled level: `s = p >> SHIFT`, clamped to 255.
- `s` is written into shadow register `shadow[idx]`. `levels` is never written by capture.
- Commit happens only after all `BINS` bins of one frame reach `shadow`. Each bin updates as `levels[i] <= max(shadow[i], levels[i] - DECAY)`. The subtraction floors at 0.
- Partial frame: a `sync` arriving before bin `BINS`-1 is captured abandons the partial frame. There is no commit, and stale `shadow` entries are overwritten by the new frame.
- Reset mid-operation: all state clears immediately. Nothing commits until a full frame after the next `sync`.

## Timing
- Pipeline, with sample accepted on cycle t:
  - t+1: registered power `p`, with valid and index.
  - t+2: `shadow[index]` written.
- Last bin accepted at cycle t_L: `levels` update and `frame_valid`=1 both occur at t_L+3. `frame_valid` is low otherwise.
- Back-to-back `ce` (every cycle) is fully supported; no stalls and no backpressure.
- A `sync` accepted at t_L+1 or t_L+2 starts the next frame normally. Commit reads `shadow` before the new frame's bin 0 write lands, because bin 0 lands at the earliest on t_L+3.
- Reset values: `levels`=0, `frame_valid`=0, FSM=`WAIT_SYNC`, `idx`=0, pipeline valids=0, `shadow`=0.

## Structure
- Shared package `fft_pkg`:
  - `LEVEL_W`=8 and `LEVEL_MAX`=255.
  - FSM state enum {`WAIT_SYNC`, `CAPTURE`, `HOLD`}.
- Sub-module `bin_power`:
  - Squarer/adder, shift and saturate as a 2-stage pipeline.
  - Parameters `WIDTH`, `SHIFT`.
  - Ports: in `valid`, `idx`, `re`, `im`; out `valid`, `idx`, `level`.
- The top handles the FSM, `shadow`, and commit/decay.

## Test plan
1. **Reset and idle.** Hold `reset_n`=0, then release with no `ce` → `levels`=0 and `frame_valid` never pulses. Drive `ce` samples without `sync` → still no pulse.
2. **Single frame.** With defaults, drive bin0 re=64,im=0; bin1 re=0,im=-128; bin2 re=3,im=4; bins3-7 zero → at t_L+3 exactly one `frame_valid` pulse. Levels are bin0=64, bin1=255 (saturated from 256), bin2=0 (25>>6), others 0.
3. **Decay.** Follow test 2 with an all-zero frame → bin0=60, bin1=251. After 16 zero frames bin0=0 and stays 0, with no wrap below zero.
4. **Gapped ce.** Repeat test 2 with `ce` low 1-5 random cycles between samples, driving garbage on `re`/`im` while `ce`=0 → results identical to test 2.
5. **Sync mid-frame.** Assert `sync` with bin 3 of a frame, then complete a full frame → exactly one `frame_valid`. Levels reflect only the full frame.
6. **Async reset mid-capture.** Pull `reset_n` low between bins 4 and 5, with no `clk` edge → `levels`=0 immediately. Samples after release are ignored until `sync`.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT bin level display path.
package fft_pkg;
  localparam int LEVEL_W   = 8;
  localparam int LEVEL_MAX = 255;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    CAPTURE,
    HOLD
  } cap_state_e;
endpackage

// File: rtl/fft_bin_levels_bin_power.sv
// Bin power |re|^2+|im|^2, registered, then shifted and clamped to an 8-bit level.
module bin_power
  import fft_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SHIFT = 6,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  output logic                    o_valid,
  output logic [IDX_W-1:0]        o_idx,
  output logic [LEVEL_W-1:0]      o_level
);

  function automatic logic [LEVEL_W-1:0] sat_level(input logic [2*WIDTH-1:0] pwr);
    logic [2*WIDTH-1:0] scaled;
    scaled = pwr >> SHIFT;
    if (scaled > (2*WIDTH)'(LEVEL_MAX)) return LEVEL_W'(LEVEL_MAX);
    return scaled[LEVEL_W-1:0];
  endfunction

  logic signed [2*WIDTH-1:0] w_sq_re_p0;
  logic signed [2*WIDTH-1:0] w_sq_im_p0;
  logic [2*WIDTH-1:0]        w_pwr_p0;
  logic [2*WIDTH-1:0]        r_pwr_p1;
  logic [IDX_W-1:0]          r_idx_p1;
  logic                      r_vld_p1;

  // Squares are non-negative and their sum peaks at 2^(2*WIDTH-1), so unsigned 2*WIDTH holds it.
  assign w_sq_re_p0 = i_re * i_re;
  assign w_sq_im_p0 = i_im * i_im;
  assign w_pwr_p0   = $unsigned(w_sq_re_p0) + $unsigned(w_sq_im_p0);

  // p0 -> p1: registered power
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= i_valid;
  end

  always_ff @(posedge clk) begin
    r_pwr_p1 <= w_pwr_p0;
    r_idx_p1 <= i_idx;
  end

  assign o_valid = r_vld_p1;
  assign o_idx   = r_idx_p1;
  assign o_level = sat_level(r_pwr_p1);

endmodule

// File: rtl/fft_bin_levels.sv
// Captures the first BINS FFT bins per frame into a shadow bank, then commits
// them frame-coherently into peak-hold levels with linear decay.
module fft_bin_levels
  import fft_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BINS  = 8,
  parameter int SHIFT = 6,
  parameter int DECAY = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    sync,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  output logic [BINS*LEVEL_W-1:0] levels,
  output logic                    frame_valid
);

  localparam int               IDX_W    = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  function automatic logic [LEVEL_W-1:0] decay_floor(input logic [LEVEL_W-1:0] lvl);
    if (int'(lvl) > DECAY) return lvl - LEVEL_W'(DECAY);
    return '0;
  endfunction

  function automatic logic [LEVEL_W-1:0] max_level(input logic [LEVEL_W-1:0] a,
                                                   input logic [LEVEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  cap_state_e         r_state;
  cap_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_vld_p0;
  logic [IDX_W-1:0]   w_idx_p0;
  logic               w_vld_p1;
  logic [IDX_W-1:0]   w_idx_p1;
  logic [LEVEL_W-1:0] w_level_p1;
  logic [LEVEL_W-1:0] r_shadow_p2 [BINS];
  logic               r_commit_p2;
  logic [LEVEL_W-1:0] r_levels [BINS];
  logic               r_frame_valid;

  // p0: capture FSM; sync always restarts at bin 0, abandoning any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_SYNC;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_vld_p0    = 1'b0;
    w_idx_p0    = '0;
    if (ce) begin
      if (sync) begin
        w_vld_p0 = 1'b1;
        if (BINS == 1) begin
          w_state_nxt = HOLD;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = CAPTURE;
          w_idx_nxt   = IDX_W'(1);
        end
      end else if (r_state == CAPTURE) begin
        w_vld_p0 = 1'b1;
        w_idx_p0 = r_idx;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = HOLD;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
    end
  end

  bin_power #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT),
    .IDX_W (IDX_W)
  ) u_bin_power (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_vld_p0),
    .i_idx   (w_idx_p0),
    .i_re    (re),
    .i_im    (im),
    .o_valid (w_vld_p1),
    .o_idx   (w_idx_p1),
    .o_level (w_level_p1)
  );

  // p1 -> p2: shadow write; only the last bin of an unbroken run can request commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BINS; i++) r_shadow_p2[i] <= '0;
      r_commit_p2 <= 1'b0;
    end else begin
      if (w_vld_p1) r_shadow_p2[w_idx_p1] <= w_level_p1;
      r_commit_p2 <= w_vld_p1 && (w_idx_p1 == LAST_IDX);
    end
  end

  // p2 -> out: commit with peak-hold and floored decay, before a new bin 0 can land
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BINS; i++) r_levels[i] <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= r_commit_p2;
      if (r_commit_p2) begin
        for (int i = 0; i < BINS; i++)
          r_levels[i] <= max_level(r_shadow_p2[i], decay_floor(r_levels[i]));
      end
    end
  end

  for (genvar g = 0; g < BINS; g++) begin : g_levels
    assign levels[LEVEL_W*g +: LEVEL_W] = r_levels[g];
  end

  assign frame_valid = r_frame_valid;

endmodule
